clint_timer: RTL and testbench

- Core-local interruptor (CLINT) timer: memory-mapped responder owning mtime and mtimecmp.
- Drives the machine timer interrupt line that the CSR unit samples as clint_mtip.
- Sits on the core's uncached MMIO path behind the address decoder.
- Accepts one single-beat read/write request at a time; returns a registered response.

---
 rtl/clint_timer_pkg.sv | 37 +++
 rtl/clint_prescaler.sv | 28 ++
 rtl/clint_timer.sv | 167 ++++++++++++++++
 tb/tb_clint_timer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_timer_pkg.sv
// Shared CLINT constants, FSM encodings and the address decode helper.
package clint_timer_pkg;

    localparam int unsigned CLINT_DATA_W = 64;
    localparam int unsigned CLINT_ADDR_W = 64;
    localparam int unsigned CLINT_STRB_W = CLINT_DATA_W / 8;

    localparam logic [63:0] CLINT_BASE         = 64'h0200_0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    // Bus FSM state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    // Result of decoding one request address
    typedef struct packed {
        logic hit_cmp;
        logic hit_time;
        logic err;
    } clint_dec_t;

    // in_window: offset upper bits are zero; off: low 16 offset bits; lsb: addr[2:0]
    function automatic clint_dec_t clint_decode(input logic        in_window,
                                                input logic [15:0] off,
                                                input logic [2:0]  lsb);
        clint_dec_t d;
        d = '0;
        if (in_window && (lsb == 3'd0)) begin
            d.hit_cmp  = (off == CLINT_MTIMECMP_OFF);
            d.hit_time = (off == CLINT_MTIME_OFF);
        end
        d.err = !(d.hit_cmp || d.hit_time);
        return d;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..TICK_DIV-1 and wrap; stays at 0 when TICK_DIV is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = (cnt == CNT_MAX);

endmodule

// File: rtl/clint_timer.sv
// CLINT timer: MMIO responder for mtime/mtimecmp driving the machine timer interrupt.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int unsigned         DATA_W   = CLINT_DATA_W,
    parameter int unsigned         ADDR_W   = CLINT_ADDR_W,
    parameter logic [ADDR_W-1:0]   BASE     = ADDR_W'(CLINT_BASE),
    parameter int unsigned         TICK_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  clint_mtip
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic                tick_c;
    logic [DATA_W-1:0]   mtime_q;
    logic [DATA_W-1:0]   mtimecmp_q;
    logic [DATA_W-1:0]   mtime_d;
    logic [DATA_W-1:0]   mtimecmp_d;
    logic                mtip_d;

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic                req_ready_d;
    logic                rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                rsp_err_d;

    logic                hs_c;
    logic [ADDR_W-1:0]   off_c;
    clint_dec_t          dec_c;
    logic                wr_cmp_c;
    logic                wr_time_c;
    logic [DATA_W-1:0]   cmp_merged_c;
    logic [DATA_W-1:0]   time_merged_c;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_c (tick_c)
    );

    assign hs_c  = req_valid & req_ready;
    assign off_c = req_addr - BASE;

    // Address decode: offset must sit inside the 64 KiB window and be 8-byte aligned
    always_comb begin
        dec_c = clint_decode(off_c[ADDR_W-1:16] == '0, off_c[15:0], req_addr[2:0]);
    end

    // Byte-lane merge of write data into the current register values
    always_comb begin
        cmp_merged_c  = mtimecmp_q;
        time_merged_c = mtime_q;
        for (int b = 0; b < STRB_W; b++) begin
            if (req_wstrb[b]) begin
                cmp_merged_c[b*8 +: 8]  = req_wdata[b*8 +: 8];
                time_merged_c[b*8 +: 8] = req_wdata[b*8 +: 8];
            end
        end
    end

    // An all-zero strobe is a no-op, so it neither loads nor suppresses the tick
    assign wr_cmp_c  = hs_c & req_write & dec_c.hit_cmp  & (|req_wstrb);
    assign wr_time_c = hs_c & req_write & dec_c.hit_time & (|req_wstrb);

    // Next register values; a bus write to mtime overrides that cycle's increment
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_time_c) begin
            mtime_d = time_merged_c;
        end else if (tick_c) begin
            mtime_d = mtime_q + DATA_W'(1);
        end
        if (wr_cmp_c) begin
            mtimecmp_d = cmp_merged_c;
        end
        mtip_d = (mtime_d >= mtimecmp_d);
    end

    // Timer registers and the interrupt level, compared on the values being loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            clint_mtip <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            clint_mtip <= mtip_d;
        end
    end

    // Bus FSM next state and registered response outputs
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                if (hs_c) begin
                    state_d     = ST_RESP;
                    req_ready_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = dec_c.err;
                    rsp_rdata_d = '0;
                    if (!req_write && dec_c.hit_cmp) begin
                        rsp_rdata_d = mtimecmp_q;
                    end else if (!req_write && dec_c.hit_time) begin
                        rsp_rdata_d = mtime_q;
                    end
                end
            end
            ST_RESP: begin
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b1;
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Bus FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: one instance with TICK_DIV=1, one with TICK_DIV=4.
module tb_clint_timer;

    localparam logic [63:0] BASE  = 64'h0200_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] A_CMP = BASE + 64'h4000;
    localparam logic [63:0] A_TIM = BASE + 64'hBFF8;

    logic        clk = 1'b0;
    logic        rst1_n, rst4_n;
    logic        v1, v4;
    logic        req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_ready;

    logic        rdy1, rv1, err1, mtip1;
    logic [63:0] rdata1;
    logic        rdy4, rv4, err4, mtip4;
    logic [63:0] rdata4;

    int          vecs = 0;
    int          errs = 0;
    longint      cyc  = 0;
    bit          chk1 = 1'b0;

    // Reference model: mtime is a linear function of the cycle number between loads
    logic [63:0] mt_val, mt_prev_val, cmp_val, cmp_prev;
    longint      mt_n, mt_prev_n, cmp_n, r4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clint_timer #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata1), .rsp_err(err1), .clint_mtip(mtip1)
    );

    clint_timer #(.TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .req_valid(v4), .req_ready(rdy4),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .rsp_valid(rv4), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata4), .rsp_err(err4), .clint_mtip(mtip4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mtime_at(input longint k);
        if (k >= mt_n) return mt_val + 64'(k - mt_n);
        return mt_prev_val + 64'(k - mt_prev_n);
    endfunction

    function automatic logic [63:0] cmp_at(input longint k);
        return (k >= cmp_n) ? cmp_val : cmp_prev;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Predict the response for a handshake at edge n and apply its effect to the model
    task automatic model_access(input bit sel, input bit wr, input logic [63:0] addr,
                                input logic [63:0] wd, input logic [7:0] st, input longint n,
                                output logic [63:0] exp_rd, output logic exp_err);
        logic [63:0] off;
        bit is_cmp, is_tim;
        off    = addr - BASE;
        is_cmp = (off == 64'h4000);
        is_tim = (off == 64'hBFF8);
        exp_err = !(is_cmp || is_tim);
        exp_rd  = '0;
        if (sel) begin
            if (!wr && is_tim) exp_rd = 64'((n - 1 - r4) / 4);
            else if (!wr && is_cmp) exp_rd = ONES;
        end else if (!wr) begin
            if (is_cmp) exp_rd = cmp_at(n - 1);
            else if (is_tim) exp_rd = mtime_at(n - 1);
        end else if (st != 8'h00) begin
            if (is_tim) begin
                logic [63:0] nv;
                nv = merge(mtime_at(n - 1), wd, st);
                mt_prev_val = mt_val;
                mt_prev_n   = mt_n;
                mt_val      = nv;
                mt_n        = n;
            end else if (is_cmp) begin
                logic [63:0] nc;
                nc = merge(cmp_at(n - 1), wd, st);
                cmp_prev = cmp_val;
                cmp_val  = nc;
                cmp_n    = n;
            end
        end
    endtask

    // One bus transaction; hold>0 keeps rsp_ready low that many extra cycles
    task automatic bus(input string tag, input bit sel, input bit wr, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] st, input int hold);
        logic [63:0] exp_rd, rd0;
        logic        exp_err, er0;
        bit          got;
        longint      n;
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = st;
        v1 = !sel; v4 = sel;
        rsp_ready = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((sel ? rdy4 : rdy1) === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            vecs++; errs++;
            $error("FAIL %s_ready_timeout observed=0 expected=1", tag);
            v1 = 1'b0; v4 = 1'b0;
            return;
        end
        n = cyc + 1;
        model_access(sel, wr, addr, wd, st, n, exp_rd, exp_err);
        @(negedge clk);
        // a follow-up read sits on the bus while the response is stalled
        v1 = !sel && (hold > 0); v4 = sel && (hold > 0);
        req_write = 1'b0; req_addr = A_TIM;
        chk({tag, "_rsp_valid"}, 64'(sel ? rv4 : rv1), 64'd1);
        rd0 = sel ? rdata4 : rdata1;
        er0 = sel ? err4 : err1;
        chk({tag, "_rdata"}, rd0, exp_rd);
        chk({tag, "_err"}, 64'(er0), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_ready"}, 64'(sel ? rdy4 : rdy1), 64'd0);
            chk({tag, "_hold_valid"}, 64'(sel ? rv4 : rv1), 64'd1);
            chk({tag, "_hold_rdata"}, sel ? rdata4 : rdata1, exp_rd);
            chk({tag, "_hold_err"}, 64'(sel ? err4 : err1), 64'(exp_err));
        end
        v1 = 1'b0; v4 = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_valid"}, 64'(sel ? rv4 : rv1), 64'd0);
        chk({tag, "_done_ready"}, 64'(sel ? rdy4 : rdy1), 64'd1);
    endtask

    // Interrupt level tracked every cycle against the model
    always @(negedge clk) begin
        if (chk1) chk("mtip_track", 64'(mtip1), 64'(mtime_at(cyc) >= cmp_at(cyc)));
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          k;
        bit          seen;
        rst1_n = 1'b0; rst4_n = 1'b0;
        v1 = 1'b0; v4 = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 1'b1;
        mt_val = '0; mt_prev_val = '0; mt_n = 0; mt_prev_n = 0;
        cmp_val = ONES; cmp_prev = ONES; cmp_n = 0; r4 = 0;
        repeat (3) @(negedge clk);

        // reset values on both instances
        chk("rst_ready1", 64'(rdy1), 64'd1);
        chk("rst_valid1", 64'(rv1), 64'd0);
        chk("rst_rdata1", rdata1, 64'd0);
        chk("rst_err1", 64'(err1), 64'd0);
        chk("rst_mtip1", 64'(mtip1), 64'd0);
        chk("rst_ready4", 64'(rdy4), 64'd1);
        chk("rst_valid4", 64'(rv4), 64'd0);
        chk("rst_mtip4", 64'(mtip4), 64'd0);

        rst1_n = 1'b1;
        mt_val = '0; mt_prev_val = '0; mt_n = cyc; mt_prev_n = cyc;
        chk1 = 1'b1;
        repeat (10) @(negedge clk);
        bus("idle_read_mtime", 1'b0, 1'b0, A_TIM, '0, 8'h00, 0);

        // mtimecmp = 0x20 then raise back to all ones
        bus("wr_cmp_20", 1'b0, 1'b1, A_CMP, 64'h20, 8'hFF, 0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mtime_at(cyc) == 64'h20) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("reach_20", 64'(seen), 64'd1);
        chk("mtip_rise", 64'(mtip1), 64'd1);
        bus("wr_cmp_ones", 1'b0, 1'b1, A_CMP, ONES, 8'hFF, 0);
        chk("mtip_fall", 64'(mtip1), 64'd0);

        // wrap from all ones to zero
        bus("wr_mtime_fe", 1'b0, 1'b1, A_TIM, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
        chk("mtip_at_ones", 64'(mtip1), 64'd1);
        @(negedge clk);
        chk("mtip_after_wrap", 64'(mtip1), 64'd0);
        bus("read_after_wrap", 1'b0, 1'b0, A_TIM, '0, 8'h00, 0);

        // partial write of the low word coinciding with a tick
        d = {32'($urandom), 32'h1234_5678};
        bus("wr_mtime_lo", 1'b0, 1'b1, A_TIM, d, 8'h0F, 0);
        bus("read_mtime_lo", 1'b0, 1'b0, A_TIM, '0, 8'h00, 0);

        // unmapped / misaligned accesses, stalled response, zero-strobe write
        bus("rd_off0", 1'b0, 1'b0, BASE, '0, 8'h00, 0);
        bus("rd_misalign", 1'b0, 1'b0, BASE + 64'h4004, '0, 8'h00, 3);
        bus("wr_misalign", 1'b0, 1'b1, BASE + 64'h4004, 64'h5, 8'hFF, 0);
        bus("wr_cmp_nostrb", 1'b0, 1'b1, A_CMP, 64'h7, 8'h00, 0);
        bus("rd_cmp_after_err", 1'b0, 1'b0, A_CMP, '0, 8'h00, 0);
        bus("rd_mtime_after_err", 1'b0, 1'b0, A_TIM, '0, 8'h00, 1);

        // randomized accesses against the model
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, 5));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case (k)
                0: bus("rnd_rd_cmp", 1'b0, 1'b0, A_CMP, '0, 8'h00, int'($urandom_range(0, 2)));
                1: bus("rnd_rd_time", 1'b0, 1'b0, A_TIM, '0, 8'h00, int'($urandom_range(0, 2)));
                2: bus("rnd_wr_cmp", 1'b0, 1'b1, A_CMP,
                       mtime_at(cyc) + 64'($urandom_range(0, 14)) - 64'd4, 8'hFF, 0);
                3: bus("rnd_wr_time", 1'b0, 1'b1, A_TIM,
                       cmp_at(cyc) - 64'($urandom_range(0, 10)), 8'hFF, int'($urandom_range(0, 2)));
                4: begin
                    d = 64'($urandom) & 64'hFFFF;
                    if (d == 64'h4000 || d == 64'hBFF8) d = d + 64'd1;
                    bus("rnd_bad", 1'b0, 1'($urandom), BASE + d, {$urandom, $urandom}, 8'hFF, 0);
                end
                default: bus("rnd_wr_part", 1'b0, 1'b1, ($urandom % 2) ? A_CMP : A_TIM,
                              {$urandom, $urandom}, 8'($urandom), 0);
            endcase
        end

        // TICK_DIV=4 instance: reset asserted while a response is pending
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (3) @(negedge clk);
        req_write = 1'b0; req_addr = A_TIM; v4 = 1'b1; rsp_ready = 1'b0;
        chk("d4_ready", 64'(rdy4), 64'd1);
        @(negedge clk);
        v4 = 1'b0;
        chk("d4_resp_pending", 64'(rv4), 64'd1);
        #2 rst4_n = 1'b0;
        #1;
        chk("d4_rst_valid", 64'(rv4), 64'd0);
        chk("d4_rst_ready", 64'(rdy4), 64'd1);
        chk("d4_rst_rdata", rdata4, 64'd0);
        chk("d4_rst_err", 64'(err4), 64'd0);
        @(negedge clk);
        rst4_n = 1'b1; r4 = cyc; rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        bus("d4_read_a", 1'b1, 1'b0, A_TIM, '0, 8'h00, 0);
        repeat (9) @(negedge clk);
        bus("d4_read_b", 1'b1, 1'b0, A_TIM, '0, 8'h00, 0);
        repeat ($urandom_range(5, 20)) @(negedge clk);
        bus("d4_read_c", 1'b1, 1'b0, A_TIM, '0, 8'h00, 2);
        bus("d4_read_cmp", 1'b1, 1'b0, A_CMP, '0, 8'h00, 0);
        chk("d4_mtip", 64'(mtip4), 64'd0);

        chk1 = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
